ami_port_arbiter: RTL and testbench

- Shares one AMI-style memory port between the accelerator's read-request channel (port 0) and write-request channel (port 1).
- Arbitrates round-robin and registers the winning request toward memory.
- Tracks outstanding transactions in an in-order tag FIFO and routes each memory response back to the port that issued it.
- Sits between the accelerator top's mem_req0/mem_req1 channels and the single memory-model/host port in the drive harness.

---
 rtl/ami_port_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_ami_port_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ami_port_arbiter.sv
// Round-robin arbiter that shares one AMI memory port between a read channel (port 0)
// and a write channel (port 1), routing in-order responses back via a tag FIFO.
// Optional stall/wait statistics are compiled in with `define AMI_ARB_STATS_EN.
module ami_port_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 512,
    parameter int SIZE_W  = 8,
    parameter int MAX_OUT = 8,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req0_is_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [SIZE_W-1:0] req0_size,
    output logic              req0_grant,
    input  logic              req1_valid,
    input  logic              req1_is_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [SIZE_W-1:0] req1_size,
    output logic              req1_grant,
    output logic              mem_req_valid,
    output logic              mem_req_is_write,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_data,
    output logic [SIZE_W-1:0] mem_req_size,
    input  logic              mem_req_grant,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    input  logic [SIZE_W-1:0] mem_resp_size,
    output logic              mem_resp_grant,
    output logic              resp0_valid,
    output logic [DATA_W-1:0] resp0_data,
    output logic [SIZE_W-1:0] resp0_size,
    input  logic              resp0_grant,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp1_data,
    output logic [SIZE_W-1:0] resp1_size,
    input  logic              resp1_grant,
    output logic [CNT_W-1:0]  rd_issued,
    output logic [CNT_W-1:0]  wr_issued,
    output logic              err_misroute,
    output logic              err_unexpected_resp,
    output logic              idle
`ifdef AMI_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  resp_wait_cycles
`endif
);

    localparam int PTR_W = $clog2(MAX_OUT);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(MAX_OUT);

    typedef enum logic {ARB, HOLD} state_t;

    state_t            state, state_n;
    logic              rr_ptr;
    logic              hold_port;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [OCC_W-1:0]  occ;
    logic              tag_mem [MAX_OUT];

    logic              any_valid, win_port, win_is_write, misroute;
    logic              can_arb, fifo_empty, head;
    logic              load, push, pop, mis_set;

    assign fifo_empty = (occ == '0);
    assign can_arb    = (state == ARB) && (occ != FULL_OCC);
    assign any_valid  = req0_valid || req1_valid;
    assign win_port   = (rr_ptr ? req1_valid : req0_valid) ? rr_ptr : ~rr_ptr;
    assign win_is_write = win_port ? req1_is_write : req0_is_write;
    assign misroute   = win_port ? !win_is_write : win_is_write;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ARB;
        else        state <= state_n;
    end

    // NOTE: every always_comb output is defaulted first so no path can infer a latch.
    always_comb begin
        state_n    = state;
        req0_grant = 1'b0;
        req1_grant = 1'b0;
        load       = 1'b0;
        push       = 1'b0;
        mis_set    = 1'b0;
        case (state)
            ARB: begin
                if (can_arb && any_valid) begin
                    req0_grant = !win_port;
                    req1_grant = win_port;
                    if (misroute) begin
                        mis_set = 1'b1;
                    end else begin
                        load    = 1'b1;
                        state_n = HOLD;
                    end
                end
            end
            HOLD: begin
                if (mem_req_grant) begin
                    push    = 1'b1;
                    state_n = ARB;
                end
            end
            default: state_n = ARB;
        endcase
    end

    assign mem_req_valid = (state == HOLD);

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr              <= 1'b0;
            hold_port           <= 1'b0;
            mem_req_is_write    <= 1'b0;
            mem_req_addr        <= '0;
            mem_req_data        <= '0;
            mem_req_size        <= '0;
            rd_issued           <= '0;
            wr_issued           <= '0;
            err_misroute        <= 1'b0;
            err_unexpected_resp <= 1'b0;
        end else begin
            if (load) begin
                hold_port        <= win_port;
                mem_req_is_write <= win_is_write;
                mem_req_addr     <= win_port ? req1_addr : req0_addr;
                mem_req_data     <= win_port ? req1_data : req0_data;
                mem_req_size     <= win_port ? req1_size : req0_size;
            end
            if (mis_set) begin
                err_misroute <= 1'b1;
                rr_ptr       <= ~rr_ptr;
            end
            if (push) begin
                rr_ptr <= ~hold_port;
                if (hold_port) wr_issued <= wr_issued + CNT_W'(1);
                else           rd_issued <= rd_issued + CNT_W'(1);
            end
            if (mem_resp_valid && fifo_empty) err_unexpected_resp <= 1'b1;
        end
    end

    // Tag FIFO: pointers and occupancy reset; storage is gated by occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // NOTE: tag storage has no reset; stale entries are never read while occ is zero.
    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= hold_port;
    end

    assign head           = tag_mem[rd_ptr];
    assign resp0_valid    = mem_resp_valid && !fifo_empty && !head;
    assign resp1_valid    = mem_resp_valid && !fifo_empty && head;
    assign resp0_data     = mem_resp_data;
    assign resp0_size     = mem_resp_size;
    assign resp1_data     = mem_resp_data;
    assign resp1_size     = mem_resp_size;
    assign mem_resp_grant = fifo_empty ? mem_resp_valid : (head ? resp1_grant : resp0_grant);
    assign pop            = mem_resp_valid && mem_resp_grant && !fifo_empty;

    assign idle = (state == ARB) && fifo_empty && !req0_valid && !req1_valid;

`ifdef AMI_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles     <= '0;
            resp_wait_cycles <= '0;
        end else begin
            if ((state == HOLD) && !mem_req_grant && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (!fifo_empty && !pop && (resp_wait_cycles != '1))
                resp_wait_cycles <= resp_wait_cycles + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ami_port_arbiter.sv
// Directed self-checking bench for ami_port_arbiter: reset, routing, round-robin,
// FIFO-full throttling, response backpressure, misroute and mid-operation reset.
module tb_ami_port_arbiter;
    localparam int ADDR_W = 64, DATA_W = 512, SIZE_W = 8, MAX_OUT = 8, CNT_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req0_valid, req0_is_write, req1_valid, req1_is_write;
    logic [ADDR_W-1:0] req0_addr, req1_addr;
    logic [DATA_W-1:0] req0_data, req1_data;
    logic [SIZE_W-1:0] req0_size, req1_size;
    logic              req0_grant, req1_grant;
    logic              mem_req_valid, mem_req_is_write, mem_req_grant;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_data;
    logic [SIZE_W-1:0] mem_req_size;
    logic              mem_resp_valid, mem_resp_grant;
    logic [DATA_W-1:0] mem_resp_data;
    logic [SIZE_W-1:0] mem_resp_size;
    logic              resp0_valid, resp1_valid, resp0_grant, resp1_grant;
    logic [DATA_W-1:0] resp0_data, resp1_data;
    logic [SIZE_W-1:0] resp0_size, resp1_size;
    logic [CNT_W-1:0]  rd_issued, wr_issued;
    logic              err_misroute, err_unexpected_resp, idle;
`ifdef AMI_ARB_STATS_EN
    logic [CNT_W-1:0]  stall_cycles, resp_wait_cycles;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    ami_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W),
                       .MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_is_write(req0_is_write), .req0_addr(req0_addr),
        .req0_data(req0_data), .req0_size(req0_size), .req0_grant(req0_grant),
        .req1_valid(req1_valid), .req1_is_write(req1_is_write), .req1_addr(req1_addr),
        .req1_data(req1_data), .req1_size(req1_size), .req1_grant(req1_grant),
        .mem_req_valid(mem_req_valid), .mem_req_is_write(mem_req_is_write),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_size(mem_req_size),
        .mem_req_grant(mem_req_grant),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .mem_resp_size(mem_resp_size), .mem_resp_grant(mem_resp_grant),
        .resp0_valid(resp0_valid), .resp0_data(resp0_data), .resp0_size(resp0_size),
        .resp0_grant(resp0_grant),
        .resp1_valid(resp1_valid), .resp1_data(resp1_data), .resp1_size(resp1_size),
        .resp1_grant(resp1_grant),
        .rd_issued(rd_issued), .wr_issued(wr_issued),
        .err_misroute(err_misroute), .err_unexpected_resp(err_unexpected_resp), .idle(idle)
`ifdef AMI_ARB_STATS_EN
        , .stall_cycles(stall_cycles), .resp_wait_cycles(resp_wait_cycles)
`endif
    );

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        mem_req_grant = 1'b0; mem_resp_valid = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req0_is_write = 1'b0; req1_is_write = 1'b1;
        req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
        req0_size = '0; req1_size = '0;
        mem_resp_data = '0; mem_resp_size = '0;
        resp0_grant = 1'b0; resp1_grant = 1'b0;
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; mem_req_grant = 1'b0; mem_resp_valid = 1'b0;
        tick();
        tick();
        tests_run++; if (mem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_req_valid: got %b want 0", mem_req_valid); end
        tests_run++; if (idle !== 1'b1) begin tests_failed++; $display("FAIL reset_idle: got %b want 1", idle); end
        tests_run++; if ({rd_issued, wr_issued} !== '0) begin tests_failed++; $display("FAIL reset_counters: got rd=%0d wr=%0d want 0", rd_issued, wr_issued); end
        tests_run++; if ({err_misroute, err_unexpected_resp, req0_grant, req1_grant} !== 4'b0) begin tests_failed++; $display("FAIL reset_flags: got %b want 0000", {err_misroute, err_unexpected_resp, req0_grant, req1_grant}); end
        tests_run++; if (mem_req_addr !== '0) begin tests_failed++; $display("FAIL reset_addr: got %h want 0", mem_req_addr); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        req0_valid = 1'b1; req0_is_write = 1'b0; req0_addr = 64'h40; req0_size = 8'd64;
        #1;
        tests_run++; if ({req0_grant, req1_grant} !== 2'b10) begin tests_failed++; $display("FAIL single_grant: got %b want 10", {req0_grant, req1_grant}); end
        tick();
        req0_valid = 1'b0;
        tests_run++; if (mem_req_valid !== 1'b1) begin tests_failed++; $display("FAIL single_mem_valid: got %b want 1", mem_req_valid); end
        tests_run++; if ({mem_req_is_write, mem_req_addr, mem_req_size} !== {1'b0, 64'h40, 8'd64}) begin tests_failed++; $display("FAIL single_fields: got w=%b a=%h s=%0d want w=0 a=40 s=64", mem_req_is_write, mem_req_addr, mem_req_size); end
        mem_req_grant = 1'b1;
        tick();
        mem_req_grant = 1'b0;
        tests_run++; if ({mem_req_valid, rd_issued} !== {1'b0, 32'd1}) begin tests_failed++; $display("FAIL single_issue: got v=%b rd=%0d want v=0 rd=1", mem_req_valid, rd_issued); end
        mem_resp_valid = 1'b1; mem_resp_data = {64{8'hAB}}; mem_resp_size = 8'd64; resp0_grant = 1'b1;
        #1;
        tests_run++; if ({resp0_valid, resp1_valid, mem_resp_grant} !== 3'b101) begin tests_failed++; $display("FAIL single_route: got r0=%b r1=%b mg=%b want 1 0 1", resp0_valid, resp1_valid, mem_resp_grant); end
        tests_run++; if (resp0_data !== {64{8'hAB}}) begin tests_failed++; $display("FAIL single_resp_data: got %h want ab..ab", resp0_data); end
        tick();
        mem_resp_valid = 1'b0; resp0_grant = 1'b0;
        #1;
        tests_run++; if (idle !== 1'b1) begin tests_failed++; $display("FAIL single_idle: got %b want 1", idle); end
    endtask

    task automatic test_round_robin();
        logic exp_port;
        apply_reset();
        req0_valid = 1'b1; req0_is_write = 1'b0; req0_addr = 64'h100;
        req1_valid = 1'b1; req1_is_write = 1'b1; req1_addr = 64'h200;
        mem_req_grant = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            exp_port = (i % 2) == 1;
            tests_run++; if ({req1_grant, req0_grant} !== (exp_port ? 2'b10 : 2'b01)) begin tests_failed++; $display("FAIL rr_grant_%0d: got g1g0=%b want port %0d", i, {req1_grant, req0_grant}, exp_port); end
            tick();
            tests_run++; if ({mem_req_valid, mem_req_is_write} !== {1'b1, exp_port}) begin tests_failed++; $display("FAIL rr_issue_%0d: got v=%b w=%b want v=1 w=%b", i, mem_req_valid, mem_req_is_write, exp_port); end
            tick();
        end
        tests_run++; if ({rd_issued, wr_issued} !== {32'd4, 32'd4}) begin tests_failed++; $display("FAIL rr_counts: got rd=%0d wr=%0d want 4 4", rd_issued, wr_issued); end
    endtask

    // Continues with a full FIFO (order 0,1,0,1,0,1,0,1) and both requests still valid.
    task automatic test_fifo_full();
        tests_run++; if ({req0_grant, req1_grant, mem_req_valid} !== 3'b000) begin tests_failed++; $display("FAIL full_no_grant: got %b want 000", {req0_grant, req1_grant, mem_req_valid}); end
        tick();
        tests_run++; if ({req0_grant, req1_grant} !== 2'b00) begin tests_failed++; $display("FAIL full_still_blocked: got %b want 00", {req0_grant, req1_grant}); end
        mem_resp_valid = 1'b1; resp0_grant = 1'b1; resp1_grant = 1'b1;
        #1;
        tests_run++; if ({resp0_valid, req0_grant, req1_grant} !== 3'b100) begin tests_failed++; $display("FAIL full_pop_cycle: got r0=%b g0=%b g1=%b want 1 0 0", resp0_valid, req0_grant, req1_grant); end
        tick();
        mem_resp_valid = 1'b0;
        #1;
        tests_run++; if ({req0_grant, req1_grant} !== 2'b10) begin tests_failed++; $display("FAIL full_ninth_grant: got %b want 10", {req0_grant, req1_grant}); end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        mem_req_grant = 1'b0;
        tests_run++; if ({rd_issued, wr_issued} !== {32'd5, 32'd4}) begin tests_failed++; $display("FAIL full_counts: got rd=%0d wr=%0d want 5 4", rd_issued, wr_issued); end
    endtask

    // FIFO now holds 1,0,1,0,1,0,1,0 with head port 1.
    task automatic test_resp_backpressure();
        mem_resp_valid = 1'b1; mem_resp_data = {16{32'h1234_5678}}; mem_resp_size = 8'd32;
        resp0_grant = 1'b1; resp1_grant = 1'b0;
        #1;
        tests_run++; if ({resp1_valid, resp0_valid, mem_resp_grant} !== 3'b100) begin tests_failed++; $display("FAIL bp_hold: got r1=%b r0=%b mg=%b want 1 0 0", resp1_valid, resp0_valid, mem_resp_grant); end
        tests_run++; if (resp1_size !== 8'd32) begin tests_failed++; $display("FAIL bp_size: got %0d want 32", resp1_size); end
        tick();
        tests_run++; if ({resp1_valid, resp0_valid} !== 2'b10) begin tests_failed++; $display("FAIL bp_stays: got r1=%b r0=%b want 1 0", resp1_valid, resp0_valid); end
        resp1_grant = 1'b1;
        #1;
        tests_run++; if (mem_resp_grant !== 1'b1) begin tests_failed++; $display("FAIL bp_release: got %b want 1", mem_resp_grant); end
        tick();
        tests_run++; if ({resp1_valid, resp0_valid} !== 2'b01) begin tests_failed++; $display("FAIL bp_next_head: got r1=%b r0=%b want 0 1", resp1_valid, resp0_valid); end
        mem_resp_valid = 1'b0; resp0_grant = 1'b0; resp1_grant = 1'b0;
    endtask

    task automatic test_reset_mid_hold();
        apply_reset();
        req0_valid = 1'b1; req0_is_write = 1'b0; req0_addr = 64'h80;
        mem_req_grant = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tick();
        end
        #1;
        tests_run++; if (rd_issued !== 32'd3) begin tests_failed++; $display("FAIL mid_pre_count: got %0d want 3", rd_issued); end
        mem_req_grant = 1'b0;
        tick();
        tests_run++; if (mem_req_valid !== 1'b1) begin tests_failed++; $display("FAIL mid_in_hold: got %b want 1", mem_req_valid); end
        rst_n = 1'b0; req0_valid = 1'b0;
        tick();
        tests_run++; if ({mem_req_valid, idle} !== 2'b01) begin tests_failed++; $display("FAIL mid_after_reset: got v=%b idle=%b want 0 1", mem_req_valid, idle); end
        tests_run++; if (rd_issued !== '0) begin tests_failed++; $display("FAIL mid_counter_clear: got %0d want 0", rd_issued); end
        rst_n = 1'b1;
        mem_resp_valid = 1'b1; resp0_grant = 1'b0;
        #1;
        tests_run++; if ({mem_resp_grant, resp0_valid, resp1_valid} !== 3'b100) begin tests_failed++; $display("FAIL mid_drop: got mg=%b r0=%b r1=%b want 1 0 0", mem_resp_grant, resp0_valid, resp1_valid); end
        tick();
        mem_resp_valid = 1'b0;
        tests_run++; if (err_unexpected_resp !== 1'b1) begin tests_failed++; $display("FAIL mid_unexpected: got %b want 1", err_unexpected_resp); end
    endtask

    task automatic test_misroute();
        apply_reset();
        req0_valid = 1'b1; req0_is_write = 1'b1;
        #1;
        tests_run++; if ({req0_grant, req1_grant} !== 2'b10) begin tests_failed++; $display("FAIL mis_grant: got %b want 10", {req0_grant, req1_grant}); end
        tick();
        tests_run++; if ({mem_req_valid, err_misroute} !== 2'b01) begin tests_failed++; $display("FAIL mis_not_issued: got v=%b err=%b want 0 1", mem_req_valid, err_misroute); end
        req0_is_write = 1'b0; req1_valid = 1'b1; req1_is_write = 1'b1; req1_addr = 64'hC0;
        #1;
        tests_run++; if ({req0_grant, req1_grant} !== 2'b01) begin tests_failed++; $display("FAIL mis_rr_flip: got g0g1=%b want 01", {req0_grant, req1_grant}); end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tests_run++; if ({mem_req_valid, mem_req_is_write, mem_req_addr, err_misroute} !== {2'b11, 64'hC0, 1'b1}) begin tests_failed++; $display("FAIL mis_sticky: got v=%b w=%b a=%h err=%b want 1 1 c0 1", mem_req_valid, mem_req_is_write, mem_req_addr, err_misroute); end
        mem_req_grant = 1'b1;
        tick();
        mem_req_grant = 1'b0;
        tests_run++; if ({rd_issued, wr_issued, err_unexpected_resp} !== {32'd0, 32'd1, 1'b0}) begin tests_failed++; $display("FAIL mis_counts: got rd=%0d wr=%0d eu=%b want 0 1 0", rd_issued, wr_issued, err_unexpected_resp); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_fifo_full();
        test_resp_backpressure();
        test_reset_mid_hold();
        test_misroute();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
